// File: rtl/sobel_frame_sequencer.sv
// Batch sequencer for an ap_ctrl_chain Sobel kernel: issues up to N frames with at
// most two in flight, and collects frame count and per-frame latency statistics.
module sobel_frame_sequencer #(
  parameter int CNT_W = 16,
  parameter int LAT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic             cfg_abort,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  output logic             k_ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             aborted,
  output logic [CNT_W-1:0] frames_done,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] launched;
  logic [1:0]       outstanding;
  logic             abort_q;
  logic             ts_pushed;
  logic [LAT_W-1:0] cycle_cnt;
  logic [LAT_W-1:0] ts_mem [2];
  logic             ts_wr;
  logic             ts_rd;

  logic             launch;
  logic             complete;
  logic             push;
  logic             aborting;
  logic             permit;
  logic [CNT_W-1:0] launched_n;
  logic [CNT_W-1:0] done_n;
  logic [1:0]       out_n;
  logic [LAT_W-1:0] latency;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    launch     = k_ap_start & k_ap_ready;
    // A done with nothing launched-and-unfinished is spurious and must not pop.
    complete   = k_ap_done & k_ap_continue & (outstanding != 2'd0);
    push       = k_ap_start & ~ts_pushed;
    aborting   = cfg_abort | abort_q;
    launched_n = launched + CNT_W'(launch);
    done_n     = (complete && frames_done != n_q) ? frames_done + CNT_W'(1) : frames_done;
    out_n      = outstanding + 2'(launch) - 2'(complete);
    permit     = (launched_n < n_q) && (out_n < 2'd2) && !aborting;
    latency    = cycle_cnt - ts_mem[ts_rd];
  end

  // NOTE: the timestamp storage has no reset; the read/write pointers define validity.
  always_ff @(posedge ap_clk) begin
    if (push) ts_mem[ts_wr] <= cycle_cnt;
  end

  // NOTE: non-blocking assignments throughout, so every term above sees pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= S_IDLE;
      n_q           <= '0;
      launched      <= '0;
      outstanding   <= 2'd0;
      abort_q       <= 1'b0;
      ts_pushed     <= 1'b0;
      cycle_cnt     <= '0;
      ts_wr         <= 1'b0;
      ts_rd         <= 1'b0;
      k_ap_start    <= 1'b0;
      k_ap_continue <= 1'b0;
      busy          <= 1'b0;
      finish        <= 1'b0;
      aborted       <= 1'b0;
      frames_done   <= '0;
      last_latency  <= '0;
      max_latency   <= '0;
    end else begin
      if (busy) cycle_cnt <= cycle_cnt + LAT_W'(1);
      if (push) ts_wr <= ~ts_wr;
      if (complete) begin
        ts_rd        <= ~ts_rd;
        last_latency <= latency;
        if (latency > max_latency) max_latency <= latency;
      end
      frames_done <= done_n;
      launched    <= launched_n;
      outstanding <= out_n;
      // Stays set while a request waits for ready; clears on the accepting cycle.
      ts_pushed   <= k_ap_start & ~k_ap_ready;

      case (state)
        S_IDLE, S_FIN: begin
          if (cfg_start) begin
            n_q          <= cfg_num_frames;
            launched     <= '0;
            outstanding  <= 2'd0;
            frames_done  <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            aborted      <= 1'b0;
            abort_q      <= 1'b0;
            ts_wr        <= 1'b0;
            ts_rd        <= 1'b0;
            if (cfg_num_frames != '0) begin
              state         <= S_RUN;
              busy          <= 1'b1;
              k_ap_continue <= 1'b1;
              k_ap_start    <= 1'b1;
              finish        <= 1'b0;
            end else begin
              state  <= S_FIN;
              finish <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cfg_abort) abort_q <= 1'b1;
          // A pending request cannot be retracted, even when aborting.
          if (k_ap_start && !k_ap_ready) begin
            k_ap_start <= 1'b1;
          end else begin
            k_ap_start <= permit;
            if (!permit && (launched_n == n_q || aborting)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_n == 2'd0) begin
            state         <= S_FIN;
            busy          <= 1'b0;
            k_ap_continue <= 1'b0;
            finish        <= 1'b1;
            aborted       <= (done_n < n_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Self-checking bench: a behavioural kernel with configurable ready/done timing and
// capacity drives the sequencer; latencies and counts are derived from observed events.
module tb_sobel_frame_sequencer;

  localparam int CNT_W = 16;
  localparam int LAT_W = 32;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_num_frames = '0;
  logic             cfg_abort = 1'b0;
  logic             k_ap_start;
  logic             k_ap_ready = 1'b0;
  logic             k_ap_done = 1'b0;
  logic             k_ap_continue;
  logic             busy;
  logic             finish;
  logic             aborted;
  logic [CNT_W-1:0] frames_done;
  logic [LAT_W-1:0] last_latency;
  logic [LAT_W-1:0] max_latency;

  sobel_frame_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .cfg_start      (cfg_start),
    .cfg_num_frames (cfg_num_frames),
    .cfg_abort      (cfg_abort),
    .k_ap_start     (k_ap_start),
    .k_ap_ready     (k_ap_ready),
    .k_ap_done      (k_ap_done),
    .k_ap_continue  (k_ap_continue),
    .busy           (busy),
    .finish         (finish),
    .aborted        (aborted),
    .frames_done    (frames_done),
    .last_latency   (last_latency),
    .max_latency    (max_latency)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int n;
    int cap;
    int rdy;
    int dly;
    int abort_frame;
    int inject;
    int exp_frames;
    int exp_launch;
    int exp_aborted;
    int exp_lat;
    int exp_peak;
  } vec_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  cap = 1;
  int  rdy_dly = 1;
  int  done_dly = 2;
  int  abort_frame = -1;
  bit  pending = 1'b0;
  bit  prev_hold = 1'b0;
  bit  inj_done = 1'b0;
  int  rise_cyc = 0;
  int  due_q[$];
  int  rise_q[$];
  int  launches = 0;
  int  completions = 0;
  int  peak = 0;
  longint exp_last = 0;
  longint exp_max = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: observe outputs of the current cycle, drive kernel responses, advance.
  task automatic tick();
    bit ready;
    bit done;
    int lat;
    if (prev_hold) check("start_held_until_ready", 64'(k_ap_start), 64'(1));
    check("continue_eq_busy", 64'(k_ap_continue), 64'(busy));
    if (k_ap_start) check("start_only_when_busy", 64'(busy), 64'(1));
    if (k_ap_start && !pending) begin
      pending  = 1'b1;
      rise_cyc = cyc;
      check("outstanding_lt2_at_start", 64'(due_q.size() < 2), 64'(1));
      if (launches == abort_frame) cfg_abort = 1'b1;
    end
    ready = k_ap_start && pending && (cyc - rise_cyc >= rdy_dly) && (due_q.size() < cap);
    done  = (due_q.size() != 0) && (due_q[0] <= cyc);
    k_ap_ready = ready;
    k_ap_done  = done | inj_done;
    if (done && k_ap_continue) begin
      void'(due_q.pop_front());
      lat = cyc - rise_q.pop_front();
      completions++;
      exp_last = lat;
      if (lat > exp_max) exp_max = lat;
    end
    if (ready) begin
      launches++;
      due_q.push_back((rise_cyc + done_dly >= cyc + 1) ? rise_cyc + done_dly : cyc + 1);
      rise_q.push_back(rise_cyc);
      pending = 1'b0;
      if (due_q.size() > peak) peak = due_q.size();
    end
    prev_hold = k_ap_start && !ready;
    @(posedge ap_clk);
    #1;
    cyc++;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    inj_done  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_k_ap_start"}, 64'(k_ap_start), 64'(0));
    check({tag, "_k_ap_continue"}, 64'(k_ap_continue), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_finish"}, 64'(finish), 64'(0));
    check({tag, "_aborted"}, 64'(aborted), 64'(0));
    check({tag, "_frames_done"}, 64'(frames_done), 64'(0));
    check({tag, "_last_latency"}, 64'(last_latency), 64'(0));
    check({tag, "_max_latency"}, 64'(max_latency), 64'(0));
  endtask

  task automatic begin_batch(input int n, input int c, input int r, input int d, input int af);
    cap = c; rdy_dly = r; done_dly = d; abort_frame = af;
    launches = 0; completions = 0; peak = 0; exp_last = 0; exp_max = 0;
    cfg_start = 1'b1;
    cfg_num_frames = CNT_W'(n);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int waited;
    logic [CNT_W-1:0] held;
    begin_batch(v.n, v.cap, v.rdy, v.dly, v.abort_frame);
    waited = 0;
    while (!finish && waited < 3000) begin
      if (waited == 0 && v.inject != 0) begin
        inj_done = 1'b1;
        cfg_start = 1'b1;
        cfg_num_frames = CNT_W'(v.n + 5);
      end
      tick();
      waited++;
      if (waited == 1 && v.inject != 0) begin
        check("spurious_done_ignored", 64'(frames_done), 64'(0));
        check("start_while_busy_ignored", 64'(busy), 64'(1));
      end
    end
    check("finish_reached", 64'(finish), 64'(1));
    if (v.n == 0) check("n0_finish_next_cycle", 64'(waited), 64'(0));
    check("fin_busy_low", 64'(busy), 64'(0));
    check("fin_start_low", 64'(k_ap_start), 64'(0));
    check("frames_done_model", 64'(frames_done), 64'(completions));
    check("aborted_model", 64'(aborted), 64'(completions < v.n));
    check("last_latency_model", 64'(last_latency), 64'(exp_last));
    check("max_latency_model", 64'(max_latency), 64'(exp_max));
    check("launch_count", 64'(launches), 64'(v.exp_launch));
    check("frames_done_expected", 64'(frames_done), 64'(v.exp_frames));
    check("aborted_expected", 64'(aborted), 64'(v.exp_aborted));
    if (v.exp_lat >= 0) begin
      check("last_latency_expected", 64'(last_latency), 64'(v.exp_lat));
      check("max_latency_expected", 64'(max_latency), 64'(v.exp_lat));
    end
    if (v.exp_peak >= 0) check("peak_outstanding", 64'(peak), 64'(v.exp_peak));
    abort_frame = -1;
    held = frames_done;
    repeat (2) tick();
    check("finish_held", 64'(finish), 64'(1));
    check("frames_done_held", 64'(frames_done), 64'(held));
  endtask

  initial begin
    int waited;
    vec_t rv;
    //             n  cap rdy dly abort inj frames launch abt lat peak
    vecs[0] = '{3, 1, 1, 10, -1, 0, 3, 3, 0, 10, 1};
    vecs[1] = '{4, 3, 2, 20, -1, 0, 4, 4, 0, 20, 2};
    vecs[2] = '{0, 1, 1, 10, -1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{5, 2, 3, 8, 1, 0, 2, 2, 1, 8, 2};
    vecs[4] = '{2, 1, 3, 9, -1, 1, 2, 2, 0, 9, 1};
    vecs[5] = '{1, 1, 0, 1, -1, 0, 1, 1, 0, 1, 1};
    vecs[6] = '{6, 3, 0, 3, -1, 0, 6, 6, 0, 3, 2};

    repeat (2) @(posedge ap_clk);
    #1;
    check_all_zero("reset");
    ap_rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset with two frames in flight, then a clean single-frame batch.
    begin_batch(4, 3, 1, 30, -1);
    waited = 0;
    while (due_q.size() < 2 && waited < 200) begin
      tick();
      waited++;
    end
    check("two_outstanding_before_reset", 64'(due_q.size()), 64'(2));
    ap_rst = 1'b1;
    k_ap_ready = 1'b0;
    k_ap_done = 1'b0;
    @(posedge ap_clk);
    #1;
    cyc++;
    ap_rst = 1'b0;
    due_q.delete();
    rise_q.delete();
    pending = 1'b0;
    prev_hold = 1'b0;
    check_all_zero("midbatch_reset");
    tick();
    run_vec('{1, 1, 1, 5, -1, 0, 1, 1, 0, 5, 1});

    for (int k = 0; k < 30; k++) begin
      rv.n = $urandom_range(1, 8);
      rv.cap = $urandom_range(1, 3);
      rv.rdy = $urandom_range(0, 3);
      rv.dly = rv.rdy + $urandom_range(1, 25);
      rv.abort_frame = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rv.n - 1) : -1;
      rv.inject = 0;
      rv.exp_launch = (rv.abort_frame >= 0) ? rv.abort_frame + 1 : rv.n;
      rv.exp_frames = rv.exp_launch;
      rv.exp_aborted = (rv.exp_frames < rv.n) ? 1 : 0;
      rv.exp_lat = -1;
      rv.exp_peak = -1;
      run_vec(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
